frame_rd_stream: RTL and testbench

FRAME_RD_STREAM -- requirements
Module: frame_rd_stream

---
 rtl/frame_rd_stream_pkg.sv | 16 +
 rtl/frame_rd_stream_if.sv | 28 ++
 rtl/frame_rd_stream_sync_fifo.sv | 55 +++++
 rtl/frame_rd_stream.sv | 131 +++++++++++++
 tb/tb_frame_rd_stream.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/frame_rd_stream_pkg.sv
// Shared types and active-level constants for the frame read streamer.
// Imported by the top-level streamer and available to its sub-modules.
package frame_rd_stream_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  localparam logic ASSERT_L   = 1'b0;
  localparam logic DEASSERT_L = 1'b1;
  localparam logic ASSERT_H   = 1'b1;
  localparam logic DEASSERT_H = 1'b0;

endpackage

// File: rtl/frame_rd_stream_if.sv
// Frame-buffer read port plus the outgoing word stream, bundled as one interface.
// The master modport is the streamer's view; slave is the buffer/sink side.
interface frame_rd_stream_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  rd_en_l;
  logic [DATA_WIDTH-1:0] buf_data;
  logic                  buf_valid;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_valid;
  logic                  out_ready;
  logic                  out_sof;
  logic                  out_eol;

  modport master (
    output rd_en_l,
    input  buf_data, buf_valid,
    output out_data, out_valid, out_sof, out_eol,
    input  out_ready
  );

  modport slave (
    input  rd_en_l,
    output buf_data, buf_valid,
    input  out_data, out_valid, out_sof, out_eol,
    output out_ready
  );
endinterface

// File: rtl/frame_rd_stream_sync_fifo.sv
// Single-clock FIFO with a combinational head read, so the oldest entry is
// visible on pop_data in the same cycle it becomes valid.
module sync_fifo #(
  parameter int WIDTH = 34,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
  localparam logic [AW:0]   CNT_MAX = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CNT_MAX);
  assign count   = count_q;
  assign do_pop  = pop && !empty;
  // A push into a full FIFO is still legal when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign pop_data = mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CNT_ONE;
        2'b01:   count_q <= count_q - CNT_ONE;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/frame_rd_stream.sv
// Streams one full frame out of a frame buffer: issues flow-controlled reads,
// prefetches returned words into a FIFO and presents them with sof/eol tags.
module frame_rd_stream
  import frame_rd_stream_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 3,
  parameter int LINE_WORDS = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  frame_rd_stream_if.master  bus,
  output logic               busy,
  output logic               ovf
);
  localparam int FRAME_WORDS = 1 << ADDR_WIDTH;
  localparam int CW          = $clog2(FIFO_DEPTH) + 1;
  localparam int FW          = DATA_WIDTH + 2;

  localparam logic [ADDR_WIDTH:0] CNT_ONE    = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH:0] FRAME_CNT  = (ADDR_WIDTH+1)'(FRAME_WORDS);
  localparam logic [ADDR_WIDTH:0] FRAME_LAST = (ADDR_WIDTH+1)'(FRAME_WORDS - 1);
  localparam logic [ADDR_WIDTH:0] LW_CNT     = (ADDR_WIDTH+1)'(LINE_WORDS);
  localparam logic [ADDR_WIDTH:0] LW_LAST    = (ADDR_WIDTH+1)'(LINE_WORDS - 1);
  localparam logic [CW:0]         OCC_LIMIT  = (CW+1)'(FIFO_DEPTH);

  if ((FRAME_WORDS % LINE_WORDS) != 0) begin : g_bad_line_words
    $error("frame_rd_stream: FRAME_WORDS must be a multiple of LINE_WORDS");
  end
  if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_fifo_depth
    $error("frame_rd_stream: FIFO_DEPTH must be a power of two >= 2");
  end

  state_e               state_q, state_d;
  logic [ADDR_WIDTH:0]  issue_cnt_q, issue_cnt_d;
  logic [ADDR_WIDTH:0]  out_cnt_q, out_cnt_d;
  logic                 inflight_q;
  logic [1:0]           tag_q, tag_d;
  logic                 discard_q;
  logic                 ovf_q, ovf_d;

  logic                 issue, push_try, push, pop, drop;
  logic [CW:0]          occupancy;
  logic [FW-1:0]        head;
  logic                 fifo_full, fifo_empty;
  logic [CW-1:0]        fifo_count;

  // Words already buffered plus the one read whose data lands this cycle.
  assign occupancy = {1'b0, fifo_count} + (CW+1)'(inflight_q);
  assign issue     = (state_q == ST_FETCH) && (occupancy < OCC_LIMIT);
  assign pop       = !fifo_empty && bus.out_ready;
  assign push_try  = bus.buf_valid && !discard_q;
  assign drop      = push_try && fifo_full && !pop;
  assign push      = push_try && !drop;

  assign bus.rd_en_l   = issue ? ASSERT_L : DEASSERT_L;
  assign bus.out_valid = !fifo_empty;
  assign bus.out_data  = head[DATA_WIDTH-1:0];
  assign bus.out_sof   = !fifo_empty && head[DATA_WIDTH+1];
  assign bus.out_eol   = !fifo_empty && head[DATA_WIDTH];
  assign busy          = (state_q != ST_IDLE) ? ASSERT_H : DEASSERT_H;
  assign ovf           = ovf_q;

  always_comb begin
    state_d     = state_q;
    issue_cnt_d = issue_cnt_q;
    out_cnt_d   = out_cnt_q;
    ovf_d       = ovf_q || drop;
    tag_d       = {(issue_cnt_q == '0), ((issue_cnt_q % LW_CNT) == LW_LAST)};

    if (pop) out_cnt_d = out_cnt_q + CNT_ONE;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d     = ST_FETCH;
          issue_cnt_d = '0;
          out_cnt_d   = '0;
        end
      end
      ST_FETCH: begin
        if (issue) begin
          issue_cnt_d = issue_cnt_q + CNT_ONE;
          if (issue_cnt_d == FRAME_CNT) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (pop && (out_cnt_q == FRAME_LAST)) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      issue_cnt_q <= '0;
      out_cnt_q   <= '0;
      inflight_q  <= 1'b0;
      tag_q       <= 2'b00;
      discard_q   <= 1'b1;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      issue_cnt_q <= issue_cnt_d;
      out_cnt_q   <= out_cnt_d;
      inflight_q  <= issue;
      tag_q       <= tag_d;
      discard_q   <= 1'b0;
      ovf_q       <= ovf_d;
    end
  end

  sync_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data ({tag_q, bus.buf_data}),
    .pop       (pop),
    .pop_data  (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

endmodule

// File: tb/tb_frame_rd_stream.sv
// Self-checking bench for frame_rd_stream: directed scenarios plus random
// frames, all compared against a word-index model of the expected stream.
module tb_frame_rd_stream;
  localparam int DW    = 32;
  localparam int FWDS  = 8;
  localparam int LW    = 4;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic busy, ovf;

  frame_rd_stream_if #(.DATA_WIDTH(DW)) bus();

  frame_rd_stream #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (3),
    .LINE_WORDS (LW),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .bus   (bus),
    .busy  (busy),
    .ovf   (ovf)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cycle  = 0;
  int frames = 0;

  // Model of one frame: words are identified by their index in the frame.
  logic [DW-1:0] mem [FWDS];
  bit            active = 0, ovf_m = 0, discard_m = 0, prev_stall = 0, inject = 0;
  int            exp_idx = 0, rd_count = 0, pushed = 0;
  bit            pend_bv = 0;
  logic [DW-1:0] pend_bd = '0;
  int            acc_cyc [FWDS];
  int            start_cyc = 0, sof_seen = 0, eol_seen = 0;
  logic [DW-1:0] last_data = '0;

  task automatic chk(input bit ok, input string name, input longint act, input longint req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cycle);
    end
  endtask

  // One clock cycle: compare DUT against the model, then advance both.
  task automatic tick();
    bit s_reset, s_start, s_valid, s_ready, s_rd, s_bv, s_pop, s_sof, s_eol, was_active;
    logic [DW-1:0] s_data;
    int level;
    #2;
    s_reset = reset;  s_start = start;
    s_valid = bus.out_valid;  s_ready = bus.out_ready;
    s_rd    = (bus.rd_en_l == 1'b0);
    s_bv    = bus.buf_valid && !discard_m;
    s_pop   = s_valid && s_ready;
    s_data  = bus.out_data;  s_sof = bus.out_sof;  s_eol = bus.out_eol;
    was_active = active;
    if (!s_reset) begin
      chk(busy == active, "busy", longint'(busy), longint'(active));
      chk(ovf == ovf_m, "ovf", longint'(ovf), longint'(ovf_m));
      if (prev_stall) chk(s_valid, "hold_valid", longint'(s_valid), 1);
      if (s_valid) begin
        if (!active) chk(1'b0, "stray_valid", 1, 0);
        else begin
          chk(s_data == mem[exp_idx % FWDS], "out_data", longint'(s_data), longint'(mem[exp_idx % FWDS]));
          chk(s_sof == (exp_idx == 0), "out_sof", longint'(s_sof), longint'(exp_idx == 0));
          chk(s_eol == ((exp_idx % LW) == LW - 1), "out_eol", longint'(s_eol),
              longint'((exp_idx % LW) == LW - 1));
        end
      end
      if (s_rd)
        chk(active && (rd_count < FWDS) && ((rd_count - exp_idx) < DEPTH), "read_issue",
            longint'(rd_count), longint'(exp_idx));
    end
    prev_stall = !s_reset && s_valid && !s_ready;
    @(posedge clk);
    pend_bv = 1'b0;
    if (s_rd) begin
      pend_bv = 1'b1;
      pend_bd = mem[rd_count % FWDS];
    end
    if (s_reset) begin
      active = 0; exp_idx = 0; rd_count = 0; pushed = 0; ovf_m = 0; discard_m = 1;
    end else begin
      discard_m = 0;
      level = pushed - exp_idx;
      if (s_bv) begin
        if (level >= DEPTH && !s_pop) ovf_m = 1;
        else pushed++;
      end
      if (s_rd) rd_count++;
      if (s_pop && active) begin
        acc_cyc[exp_idx % FWDS] = cycle;
        if (s_sof) sof_seen++;
        if (s_eol) eol_seen++;
        last_data = s_data;
        exp_idx++;
        if (exp_idx == FWDS) active = 0;
      end
      if (s_start && !was_active) begin
        active = 1; exp_idx = 0; rd_count = 0; pushed = 0;
        sof_seen = 0; eol_seen = 0; start_cyc = cycle;
      end
    end
    #1;
    bus.buf_valid = pend_bv || inject;
    bus.buf_data  = inject ? 32'hDEAD_BEEF : pend_bd;
    inject = 0;
    cycle++;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic wait_idle(input int max_cycles);
    int n = 0;
    while (active && n < max_cycles) begin
      tick();
      n++;
    end
    if (active) chk(1'b0, "frame_timeout", longint'(exp_idx), FWDS);
    tick();
    frames++;
    $display("frame %0d: %0d reads, %0d words, sof=%0d eol=%0d, cycle %0d",
             frames, rd_count, exp_idx, sof_seen, eol_seen, cycle);
  endtask

  initial begin
    bus.buf_valid = 1'b0;
    bus.buf_data  = '0;
    bus.out_ready = 1'b0;
    for (int i = 0; i < FWDS; i++) mem[i] = DW'(i);

    // Reset state
    tick();
    do_reset();
    chk(bus.out_valid == 1'b0, "rst_out_valid", longint'(bus.out_valid), 0);
    chk(bus.rd_en_l == 1'b1, "rst_rd_en_l", longint'(bus.rd_en_l), 1);
    chk(busy == 1'b0, "rst_busy", longint'(busy), 0);
    chk(ovf == 1'b0, "rst_ovf", longint'(ovf), 0);
    tick();

    // Full-rate frame: words 0..7 on consecutive cycles
    bus.out_ready = 1'b1;
    pulse_start();
    wait_idle(100);
    chk(acc_cyc[0] - start_cyc == 3, "first_latency", longint'(acc_cyc[0] - start_cyc), 3);
    chk(acc_cyc[7] - acc_cyc[0] == 7, "throughput", longint'(acc_cyc[7] - acc_cyc[0]), 7);
    chk(rd_count == 8, "reads_per_frame", longint'(rd_count), 8);
    chk(sof_seen == 1, "sof_count", longint'(sof_seen), 1);
    chk(eol_seen == 2, "eol_count", longint'(eol_seen), 2);
    chk(last_data == 32'd7, "last_word", longint'(last_data), 7);
    chk(busy == 1'b0, "busy_after_frame", longint'(busy), 0);

    // Stalled sink: prefetch fills the FIFO and stops
    bus.out_ready = 1'b0;
    pulse_start();
    repeat (9) tick();
    chk(rd_count == 4, "stall_reads", longint'(rd_count), 4);
    chk(bus.out_valid == 1'b1, "stall_valid", longint'(bus.out_valid), 1);
    chk(bus.out_data == 32'd0, "stall_head", longint'(bus.out_data), 0);
    chk(ovf == 1'b0, "stall_no_ovf", longint'(ovf), 0);
    bus.out_ready = 1'b1;
    wait_idle(100);
    chk(exp_idx == 8, "stall_words", longint'(exp_idx), 8);

    // Sink ready toggling every cycle
    pulse_start();
    for (int n = 0; n < 100 && active; n++) begin
      bus.out_ready = cycle[0];
      tick();
    end
    bus.out_ready = 1'b1;
    wait_idle(50);
    chk(exp_idx == 8 && rd_count == 8, "toggle_words", longint'(exp_idx), 8);

    // start re-pulsed mid-frame is ignored
    pulse_start();
    tick();
    tick();
    pulse_start();
    wait_idle(100);
    chk(rd_count == 8, "restart_reads", longint'(rd_count), 8);
    chk(exp_idx == 8, "restart_words", longint'(exp_idx), 8);
    tick();

    // Reset after word 2 accepted aborts the frame
    pulse_start();
    for (int n = 0; n < 50 && exp_idx < 3; n++) tick();
    do_reset();
    chk(bus.out_valid == 1'b0, "abort_out_valid", longint'(bus.out_valid), 0);
    chk(bus.rd_en_l == 1'b1, "abort_rd_en_l", longint'(bus.rd_en_l), 1);
    chk(busy == 1'b0, "abort_busy", longint'(busy), 0);
    repeat (3) tick();
    pulse_start();
    wait_idle(100);
    chk(sof_seen == 1 && exp_idx == 8, "after_abort", longint'(sof_seen), 1);

    // Extra buf_valid while FIFO full sets sticky ovf
    bus.out_ready = 1'b0;
    pulse_start();
    repeat (10) tick();
    chk(pushed - exp_idx == DEPTH, "fifo_full_model", longint'(pushed - exp_idx), DEPTH);
    inject = 1;
    tick();
    tick();
    tick();
    chk(ovf == 1'b1, "ovf_set", longint'(ovf), 1);
    bus.out_ready = 1'b1;
    wait_idle(100);
    chk(ovf == 1'b1, "ovf_sticky", longint'(ovf), 1);
    do_reset();
    chk(ovf == 1'b0, "ovf_cleared", longint'(ovf), 0);
    tick();

    // Random frames with random sink stalls and stray start pulses
    for (int f = 0; f < 20; f++) begin
      int p;
      for (int i = 0; i < FWDS; i++) mem[i] = $urandom;
      p = $urandom_range(1, 4);
      bus.out_ready = ($urandom_range(0, 3) < p);
      pulse_start();
      for (int n = 0; n < 400 && active; n++) begin
        bus.out_ready = ($urandom_range(0, 3) < p);
        start = ($urandom_range(0, 7) == 0) && (exp_idx < 6);
        tick();
      end
      start = 1'b0;
      bus.out_ready = 1'b1;
      wait_idle(50);
      chk(rd_count == FWDS, "rand_reads", longint'(rd_count), FWDS);
      chk(exp_idx == FWDS, "rand_words", longint'(exp_idx), FWDS);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cycle);
    $fatal(1, "watchdog");
  end

endmodule
